mips_multicycle_core: RTL and testbench

- Multicycle successor to the single-cycle MIPS processor top.
- Executes one instruction over 3–5 states of a control FSM and shares one external word memory for instruction and data, with a valid/ready handshake that tolerates any number of wait states.
- Adds lw/sw, slt, j and illegal-instruction trapping, with a parametrised reset vector and address width.
- Sits between the board-level memory/bus wrapper and the debug/LED logic. That logic observes `alu_result_o`, `pc_o` and `retire_o`.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/mips_mc_regfile.sv | 27 ++
 rtl/mips_multicycle_core.sv | 212 +++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Opcodes, funct codes, ALU encoding and FSM states shared by the multicycle MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL
    } alu_op_e;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // sll shifts the second operand (rt) by the instruction's shamt field.
    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] shamt);
        logic [31:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_NOR: r = ~(a | b);
            ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLL: r = b << shamt;
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, $0 reads zero.
module mips_mc_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: one shared word memory behind a valid/ready handshake,
// FETCH/DECODE/EXEC/MEM/WB control FSM with a terminal TRAP state.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic [31:0]           alu_result_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  retire_o,
    output logic                  trap_o
);

    state_e                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [31:0]           ir, a_q, b_q, alu_out, mdr, alu_n;
    logic                  retire_q, retire_n;
    logic                  pc_we, ir_we, ab_we, alu_we, mdr_we, rf_we;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, rf_wa;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext, pc_ext, jump_target;
    logic [31:0] rs_val, rt_val, alu_b, alu_res, rf_wd;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign imm_sext = sext16(imm);
    assign imm_zext = {16'h0, imm};
    assign pc_ext   = 32'(pc);

    logic    legal, use_imm, zext_imm, is_rtype, is_mem, is_branch, is_jump;
    logic    is_lw, is_sw, br_taken;
    alu_op_e alu_op;

    always_comb begin
        legal     = 1'b1;
        use_imm   = 1'b0;
        zext_imm  = 1'b0;
        is_rtype  = 1'b0;
        is_mem    = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    default: legal  = 1'b0;
                endcase
            end
            OP_ADDI: use_imm = 1'b1;
            OP_ORI: begin
                use_imm  = 1'b1;
                zext_imm = 1'b1;
                alu_op   = ALU_OR;
            end
            OP_LW, OP_SW: begin
                use_imm = 1'b1;
                is_mem  = 1'b1;
            end
            OP_BEQ, OP_BNE: is_branch = 1'b1;
            OP_J:           is_jump   = 1'b1;
            default:        legal     = 1'b0;
        endcase
    end

    assign is_lw       = (opcode == OP_LW);
    assign is_sw       = (opcode == OP_SW);
    assign alu_b       = use_imm ? (zext_imm ? imm_zext : imm_sext) : b_q;
    assign alu_res     = alu_eval(alu_op, a_q, alu_b, shamt);
    assign br_taken    = (a_q == b_q) ^ (opcode == OP_BNE);
    assign jump_target = {pc_ext[31:28], ir[25:0], 2'b00};
    assign rf_wa       = is_rtype ? rd : rt;
    assign rf_wd       = is_lw ? mdr : alu_out;

    mips_mc_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        pc_we    = 1'b0;
        pc_n     = pc + ADDR_WIDTH'(4);
        ir_we    = 1'b0;
        ab_we    = 1'b0;
        alu_we   = 1'b0;
        alu_n    = alu_res;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        retire_n = 1'b0;
        case (state)
            FETCH: begin
                if (mem_ready_i) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                // Branch target is computed speculatively while operands are latched.
                ab_we   = 1'b1;
                alu_we  = 1'b1;
                alu_n   = pc_ext + {imm_sext[29:0], 2'b00};
                state_n = legal ? EXEC : TRAP;
            end
            EXEC: begin
                if (is_mem) begin
                    alu_we  = 1'b1;
                    state_n = (alu_res[1:0] != 2'b00) ? TRAP : MEM;
                end else if (is_branch) begin
                    pc_we    = br_taken;
                    pc_n     = alu_out[ADDR_WIDTH-1:0];
                    retire_n = 1'b1;
                    state_n  = FETCH;
                end else if (is_jump) begin
                    pc_we    = 1'b1;
                    pc_n     = jump_target[ADDR_WIDTH-1:0];
                    retire_n = 1'b1;
                    state_n  = FETCH;
                end else begin
                    alu_we  = 1'b1;
                    state_n = WB;
                end
            end
            MEM: begin
                if (mem_ready_i) begin
                    if (is_sw) begin
                        retire_n = 1'b1;
                        state_n  = FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_n = WB;
                    end
                end
            end
            WB: begin
                rf_we    = 1'b1;
                retire_n = 1'b1;
                state_n  = FETCH;
            end
            default: state_n = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC[ADDR_WIDTH-1:0];
            ir       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            retire_q <= 1'b0;
        end else begin
            if (pc_we)  pc <= pc_n;
            if (ir_we)  ir <= mem_rdata_i;
            if (ab_we) begin
                a_q <= rs_val;
                b_q <= rt_val;
            end
            if (alu_we) alu_out <= alu_n;
            if (mdr_we) mdr <= mem_rdata_i;
            retire_q <= retire_n;
        end
    end

    // Request is gated by reset so it drops the moment reset asserts.
    assign mem_req_o    = reset && ((state == FETCH) || (state == MEM));
    assign mem_we_o     = (state == MEM) && is_sw;
    assign mem_addr_o   = (state == MEM) ? alu_out[ADDR_WIDTH-1:0] : pc;
    assign mem_wdata_o  = b_q;
    assign alu_result_o = alu_out;
    assign pc_o         = pc;
    assign retire_o     = retire_q;
    assign trap_o       = (state == TRAP);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: ISA-level reference model, directed programs and random programs.
module tb_mips_multicycle_core;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, alu_result, pc;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    int          wait_n = 0;
    int          wcnt;
    int          ecnt;
    int          pi;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_dmem [64];
    logic [31:0] m_pc;
    int          last_e;
    logic [63:0] wr_q [$];
    logic        prev_stall, prev_we;
    logic [31:0] prev_addr, prev_wdata;

    mips_multicycle_core #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready),
        .alu_result_o (alu_result),
        .pc_o         (pc),
        .retire_o     (retire),
        .trap_o       (trap)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr[31:16] == 16'h0040) mem_rdata = imem[mem_addr[7:2]];
        else                             mem_rdata = dmem[mem_addr[7:2]];
    end

    assign mem_ready = mem_req && (wcnt >= wait_n);

    always @(posedge clk or negedge reset) begin
        if (!reset)                    wcnt <= 0;
        else if (!mem_req || mem_ready) wcnt <= 0;
        else                           wcnt <= wcnt + 1;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs,
                                          input int rt, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs,
                                          input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input logic [31:0] tgt);
        return {6'h02, tgt[27:2]};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        pi = 0;
    endtask

    task automatic emit(input logic [31:0] w);
        imem[pi] = w;
        pi++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_pc = RESET_PC;
        m_dmem = dmem;
        last_e = 0;
        wr_q.delete();
        prev_stall = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_retire", retire, 0);
        chk("rst_trap", trap, 0);
        chk("rst_alu", alu_result, 0);
        chk("rst_pc", pc, RESET_PC);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("first_req", mem_req, 1);
        chk("first_we", mem_we, 0);
        chk("first_addr", mem_addr, RESET_PC);
    endtask

    // Executes the retired instruction architecturally and compares observable state.
    task automatic retire_check();
        logic [31:0] ins, a, b, se, ze, npc, ao, r, addr;
        logic [63:0] w;
        logic [4:0]  dst;
        logic        wr;
        int          cyc, nreq;
        ins  = imem[(m_pc - RESET_PC) >> 2];
        a    = m_rf[ins[25:21]];
        b    = m_rf[ins[20:16]];
        se   = {{16{ins[15]}}, ins[15:0]};
        ze   = {16'h0, ins[15:0]};
        npc  = m_pc + 32'd4;
        ao   = npc + (se << 2);
        addr = a + se;
        cyc  = 4;
        nreq = 1;
        wr   = 1'b0;
        dst  = ins[20:16];
        r    = 32'h0;
        case (ins[31:26])
            6'h00: begin
                wr  = 1'b1;
                dst = ins[15:11];
                case (ins[5:0])
                    6'h20:   r = a + b;
                    6'h22:   r = a - b;
                    6'h24:   r = a & b;
                    6'h25:   r = a | b;
                    6'h27:   r = ~(a | b);
                    6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: r = b << ins[10:6];
                endcase
                ao = r;
            end
            6'h08: begin wr = 1'b1; r = a + se; ao = r; end
            6'h0D: begin wr = 1'b1; r = a | ze; ao = r; end
            6'h23: begin
                wr = 1'b1; r = m_dmem[addr[7:2]]; ao = addr; cyc = 5; nreq = 2;
            end
            6'h2B: begin
                ao = addr; nreq = 2;
                m_dmem[addr[7:2]] = b;
                chk("store_seen", wr_q.size(), 1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    chk("store_addr", w[63:32], addr);
                    chk("store_data", w[31:0], b);
                end
            end
            6'h04: begin cyc = 3; if (a == b) npc = ao; end
            6'h05: begin cyc = 3; if (a != b) npc = ao; end
            default: begin cyc = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
        endcase
        if (wr && dst != 5'd0) m_rf[dst] = r;
        cyc += wait_n * nreq;
        chk("cpi", ecnt - last_e, cyc);
        last_e = ecnt;
        chk("pc", pc, npc);
        chk("alu_result", alu_result, ao);
        chk("no_trap", trap, 0);
        m_pc = npc;
    endtask

    task automatic run(input int n_ret);
        int got = 0;
        int budget = n_ret * (6 + 2 * wait_n) + 20;
        while (got < n_ret && budget > 0) begin
            @(negedge clk);
            budget--;
            if (prev_stall && mem_req) begin
                chk("stall_addr", mem_addr, prev_addr);
                chk("stall_we", mem_we, prev_we);
                chk("stall_wdata", mem_wdata, prev_wdata);
            end
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            if (mem_req && mem_we && mem_ready) begin
                wr_q.push_back({mem_addr, mem_wdata});
                dmem[mem_addr[7:2]] = mem_wdata;
            end
            if (retire) begin
                retire_check();
                got++;
            end
        end
        chk("retire_count", got, n_ret);
    endtask

    task automatic rand_prog();
        int kind, rd, rs, rt;
        logic [5:0] fn;
        clear_prog();
        for (int k = 1; k < 8; k++) emit(i_ins(6'h08, k, 0, int'($urandom_range(0, 65535))));
        for (int n = 0; n < 20; n++) begin
            kind = int'($urandom_range(0, 10));
            rd   = int'($urandom_range(1, 7));
            rs   = int'($urandom_range(0, 7));
            rt   = int'($urandom_range(0, 7));
            case (kind)
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h27;
                5: fn = 6'h2A;
                default: fn = 6'h00;
            endcase
            if (kind <= 5)       emit(r_ins(fn, rd, rs, rt, 0));
            else if (kind == 6)  emit(r_ins(fn, rd, rs, rt, int'($urandom_range(0, 31))));
            else if (kind == 7)  emit(i_ins(6'h08, rd, rs, int'($urandom_range(0, 65535))));
            else if (kind == 8)  emit(i_ins(6'h0D, rd, rs, int'($urandom_range(0, 65535))));
            else if (kind == 9)  emit(i_ins(6'h23, rd, 0, 4 * int'($urandom_range(0, 63))));
            else                 emit(i_ins(6'h2B, rt, 0, 4 * int'($urandom_range(0, 63))));
        end
        for (int k = 1; k < 8; k++) emit(i_ins(6'h2B, k, 0, 128 + 4 * k));
        emit(i_ins(6'h04, 0, 0, -1));
        for (int i = 0; i < 64; i++) dmem[i] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = 32'h0;

        // Arithmetic sequence, then the result is stored; ends in a branch-to-self loop.
        clear_prog();
        emit(i_ins(6'h08, 1, 0, 5));
        emit(i_ins(6'h08, 2, 0, -3));
        emit(r_ins(6'h20, 3, 1, 2, 0));
        emit(i_ins(6'h2B, 3, 0, 0));
        emit(i_ins(6'h04, 0, 0, -1));
        wait_n = 0;
        do_reset();
        run(8);

        // ori / sw / lw round trip, zero wait states and then three wait states per request.
        clear_prog();
        emit(i_ins(6'h0D, 4, 0, 16'hFFFF));
        emit(i_ins(6'h2B, 4, 0, 8));
        emit(i_ins(6'h23, 5, 0, 8));
        emit(i_ins(6'h2B, 5, 0, 12));
        emit(i_ins(6'h04, 0, 0, -1));
        for (int w = 0; w < 4; w += 3) begin
            wait_n = w;
            do_reset();
            run(6);
        end

        // bne skips one instruction; j returns to the reset vector and the loop repeats.
        clear_prog();
        emit(i_ins(6'h08, 1, 0, 1));
        emit(i_ins(6'h05, 0, 1, 1));
        emit(i_ins(6'h08, 7, 0, 9));
        emit(i_ins(6'h08, 8, 0, 9));
        emit(i_ins(6'h2B, 7, 0, 16));
        emit(i_ins(6'h2B, 8, 0, 20));
        emit(j_ins(RESET_PC));
        wait_n = 0;
        do_reset();
        run(12);

        for (int t = 0; t < 3; t++) begin
            rand_prog();
            wait_n = (t == 0) ? 0 : int'($urandom_range(1, 3));
            do_reset();
            run(37);
        end

        // Misaligned lw traps after EXEC.
        clear_prog();
        emit(i_ins(6'h23, 2, 0, 2));
        wait_n = 0;
        do_reset();
        repeat (2) @(negedge clk);
        chk("mis_trap_early", trap, 0);
        @(negedge clk);
        chk("mis_trap", trap, 1);
        repeat (4) begin
            @(negedge clk);
            chk("mis_no_req", mem_req, 0);
        end
        chk("mis_pc_frozen", pc, RESET_PC + 32'd4);

        // Illegal opcode and illegal funct trap after DECODE.
        for (int k = 0; k < 2; k++) begin
            clear_prog();
            emit((k == 0) ? 32'hFC00_0000 : r_ins(6'h3F, 1, 2, 3, 0));
            do_reset();
            @(negedge clk);
            chk("ill_trap_early", trap, 0);
            @(negedge clk);
            chk("ill_trap", trap, 1);
            repeat (3) begin
                @(negedge clk);
                chk("ill_no_req", mem_req, 0);
            end
            chk("ill_pc_frozen", pc, RESET_PC + 32'd4);
        end

        // Reset clears the trap and execution restarts normally.
        clear_prog();
        emit(i_ins(6'h08, 6, 0, 77));
        emit(i_ins(6'h2B, 6, 0, 24));
        emit(i_ins(6'h04, 0, 0, -1));
        do_reset();
        run(3);

        // Reset asserted while a sw waits in MEM aborts it without touching memory.
        begin
            int  budget = 40;
            bool_block: begin end
            clear_prog();
            emit(i_ins(6'h2B, 0, 0, 12));
            dmem[3] = 32'hDEAD_BEEF;
            wait_n = 3;
            do_reset();
            while (budget > 0 && !(mem_req && mem_we)) begin
                @(negedge clk);
                budget--;
                if (mem_req && mem_we && mem_ready) dmem[mem_addr[7:2]] = mem_wdata;
            end
            chk("sw_mem_reached", budget > 0, 1);
            #2 reset = 1'b0;
            #1;
            chk("abort_req", mem_req, 0);
            repeat (2) @(negedge clk);
            chk("abort_mem_unchanged", dmem[3], 32'hDEAD_BEEF);
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
